// File: rtl/axi_master_read_burst_if.sv
// AXI4 read-address / read-data channel bundle between axi_master_read_burst and the DDR slave port.
interface axi_master_read_burst_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]   M_AXI_ARID;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [7:0]        M_AXI_ARLEN;
    logic [2:0]        M_AXI_ARSIZE;
    logic [1:0]        M_AXI_ARBURST;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [ID_W-1:0]   M_AXI_RID;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RLAST;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RVALID
    );
endinterface

// File: rtl/axi_master_read_burst.sv
// AXI4 read master: splits one user request into INCR bursts capped at MAX_BURST beats and
// never crossing a 4 KB page, streams beats straight into the read FIFO and flags errors.
module axi_master_read_burst #(
    parameter int              DATA_W    = 256,
    parameter int              ADDR_W    = 32,
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] ARID_VAL  = '0,
    parameter int              MAX_BURST = 64,
    parameter int              LEN_W     = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    axi_master_read_burst_if.master m_axi,
    input  logic                    RD_START,
    input  logic [ADDR_W-1:0]       RD_ADRS,
    input  logic [LEN_W-1:0]        RD_LEN,
    output logic                    RD_READY,
    output logic                    RD_FIFO_WE,
    output logic [DATA_W-1:0]       RD_FIFO_DATA,
    input  logic                    RD_FIFO_AFULL,
    output logic                    RD_DONE,
    output logic                    RD_ERR
);
    localparam int                BYTES      = DATA_W / 8;
    localparam int                SIZE       = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining, rem_after;
    logic              err;
    logic [8:0]        blen, blen_calc, beat_cnt;
    logic [9:0]        beat_num;
    logic [12:0]       to4k;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              arvalid, rready, r_hs, beat_err;

    assign m_axi.M_AXI_ARID    = ARID_VAL;
    assign m_axi.M_AXI_ARADDR  = araddr;
    assign m_axi.M_AXI_ARLEN   = arlen;
    assign m_axi.M_AXI_ARSIZE  = 3'(SIZE);
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_ARVALID = arvalid;
    assign m_axi.M_AXI_RREADY  = rready;

    // No data register: the FIFO sees the bus beat in the same cycle it is accepted.
    assign RD_FIFO_WE   = m_axi.M_AXI_RVALID & rready;
    assign RD_FIFO_DATA = m_axi.M_AXI_RDATA;
    assign r_hs         = RD_FIFO_WE;

    // Burst length is the smallest of what is left, the burst cap and the room to the 4 KB page end.
    always_comb begin
        to4k      = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE;
        blen_calc = 9'(MAX_BURST);
        if (32'(to4k) < 32'(blen_calc))      blen_calc = 9'(to4k);
        if (32'(remaining) < 32'(blen_calc)) blen_calc = 9'(remaining);
    end

    assign rem_after = (32'(remaining) > 32'(blen)) ? remaining - LEN_W'(blen) : '0;
    assign beat_num  = {1'b0, beat_cnt} + 10'd1;
    assign beat_err  = (m_axi.M_AXI_RRESP != 2'b00) ||
                       (m_axi.M_AXI_RID != ARID_VAL) ||
                       (m_axi.M_AXI_RLAST != (beat_num == {1'b0, blen}));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_nxt = state;
        rready    = 1'b0;
        RD_READY  = 1'b0;
        RD_DONE   = 1'b0;
        RD_ERR    = 1'b0;
        unique case (state)
            S_IDLE: begin
                RD_READY = 1'b1;
                if (RD_START) state_nxt = (RD_LEN == '0) ? S_DONE : S_CALC;
            end
            S_CALC: state_nxt = S_ADDR;
            S_ADDR: if (arvalid && m_axi.M_AXI_ARREADY) state_nxt = S_DATA;
            S_DATA: begin
                rready = ~RD_FIFO_AFULL;
                if (m_axi.M_AXI_RVALID && rready && m_axi.M_AXI_RLAST)
                    state_nxt = (rem_after == '0) ? S_DONE : S_CALC;
            end
            S_DONE: begin
                RD_DONE   = 1'b1;
                RD_ERR    = err;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr      <= '0;
            remaining <= '0;
            err       <= 1'b0;
            blen      <= '0;
            beat_cnt  <= '0;
            araddr    <= '0;
            arlen     <= '0;
            arvalid   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (RD_START) begin
                    addr      <= RD_ADRS & ALIGN_MASK;
                    remaining <= RD_LEN;
                    err       <= 1'b0;
                end
                S_CALC: begin
                    blen    <= blen_calc;
                    araddr  <= addr;
                    arlen   <= 8'(blen_calc - 9'd1);
                    arvalid <= 1'b1;
                end
                S_ADDR: if (m_axi.M_AXI_ARREADY) begin
                    arvalid  <= 1'b0;
                    beat_cnt <= '0;
                end
                S_DATA: if (r_hs) begin
                    // Saturate so runaway bursts past blen keep being flagged instead of wrapping.
                    if (beat_cnt != '1) beat_cnt <= beat_cnt + 9'd1;
                    if (beat_err) err <= 1'b1;
                    if (m_axi.M_AXI_RLAST) begin
                        addr      <= addr + (ADDR_W'(blen) << SIZE);
                        remaining <= rem_after;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_master_read_burst.sv
// Self-checking bench for axi_master_read_burst: randomised AXI slave plus a burst-split
// reference model computed from the address/length rules.
module tb_axi_master_read_burst;
  localparam int              DATA_W    = 256;
  localparam int              ADDR_W    = 32;
  localparam int              ID_W      = 4;
  localparam int              MAX_BURST = 64;
  localparam int              LEN_W     = 16;
  localparam int              BYTES     = DATA_W / 8;
  localparam logic [ID_W-1:0] ARID_VAL  = 4'd5;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_adrs;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ready, rd_fifo_we, rd_fifo_afull, rd_done, rd_err;
  logic [DATA_W-1:0] rd_fifo_data;

  axi_master_read_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) axi ();

  axi_master_read_burst #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .ARID_VAL(ARID_VAL),
    .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)
  ) dut (
    .ACLK(aclk), .ARESETN(aresetn), .m_axi(axi),
    .RD_START(rd_start), .RD_ADRS(rd_adrs), .RD_LEN(rd_len), .RD_READY(rd_ready),
    .RD_FIFO_WE(rd_fifo_we), .RD_FIFO_DATA(rd_fifo_data), .RD_FIFO_AFULL(rd_fifo_afull),
    .RD_DONE(rd_done), .RD_ERR(rd_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Observed traffic, expected bursts and slave behaviour knobs
  logic [ADDR_W-1:0] ar_addr_q[$], exp_addr_q[$];
  logic [7:0]        ar_len_q[$], exp_len_q[$];
  logic [DATA_W-1:0] sent_q[$], wr_q[$];
  int  pend_q[$];
  int  cyc = 0, cur_beat = 0, req_beat = 0;
  int  done_cycles = 0, done_cyc = 0, last_wr_cyc = 0;
  logic done_err = 1'b0;
  int  stall_wr = 0, stall_cycles = 0, rready_bad = 0, ar_unstable = 0;
  bit  ar_rand = 0, rv_rand = 0, af_rand = 0, bp_mode = 0;
  int  err_beat = 0, early_last = 0;
  logic [ADDR_W-1:0] r_addr;
  int  r_len;

  logic [7:0]        t2_len[5]  = '{8'd63, 8'd63, 8'd63, 8'd63, 8'd43};
  logic [ADDR_W-1:0] t2_addr[5] = '{32'h0, 32'h800, 32'h1000, 32'h1800, 32'h2000};

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: split [a0, a0+len beats) into bursts by the cap and 4 KB page rules.
  task automatic build_model(input logic [ADDR_W-1:0] a0, input int len);
    logic [ADDR_W-1:0] a;
    int r, to4k, b;
    exp_addr_q.delete();
    exp_len_q.delete();
    a = a0 & ~ADDR_W'(BYTES - 1);
    r = len;
    while (r > 0) begin
      to4k = (4096 - int'(a % 4096)) / BYTES;
      b = (r < MAX_BURST) ? r : MAX_BURST;
      if (to4k < b) b = to4k;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(8'(b - 1));
      a = a + ADDR_W'(b * BYTES);
      r -= b;
    end
  endtask

  task automatic clear_req();
    ar_addr_q.delete(); ar_len_q.delete(); sent_q.delete(); wr_q.delete();
    done_cycles = 0; done_err = 1'b0; done_cyc = 0; last_wr_cyc = 0; req_beat = 0;
    stall_wr = 0; stall_cycles = 0; rready_bad = 0; ar_unstable = 0;
  endtask

  task automatic start_req(input string tag, input logic [ADDR_W-1:0] a, input int len);
    check({tag, ":rd_ready_before"}, rd_ready, 1'b1);
    rd_adrs  = a;
    rd_len   = LEN_W'(len);
    rd_start = 1'b1;
    @(posedge aclk); #1;
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cycles == 0 && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    check({tag, ":done_seen"}, (done_cycles != 0), 1'b1);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic verify(input string tag, input int exp_writes, input logic exp_err);
    check({tag, ":burst_count"}, ar_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < ar_addr_q.size(); i++) begin
      check($sformatf("%s:araddr[%0d]", tag, i), ar_addr_q[i], exp_addr_q[i]);
      check($sformatf("%s:arlen[%0d]", tag, i), ar_len_q[i], exp_len_q[i]);
    end
    check({tag, ":writes"}, wr_q.size(), exp_writes);
    check({tag, ":writes_vs_beats"}, wr_q.size(), sent_q.size());
    for (int i = 0; i < wr_q.size() && i < sent_q.size(); i++)
      check($sformatf("%s:data[%0d]", tag, i), wr_q[i], sent_q[i]);
    check({tag, ":done_width"}, done_cycles, 1);
    check({tag, ":rd_err"}, done_err, exp_err);
    if (exp_writes > 0) check({tag, ":done_latency"}, done_cyc, last_wr_cyc + 1);
    check({tag, ":write_while_stalled"}, stall_wr, 0);
    check({tag, ":rready_vs_afull"}, rready_bad, 0);
    check({tag, ":ar_stability"}, ar_unstable, 0);
  endtask

  task automatic run_req(input string tag, input logic [ADDR_W-1:0] a, input int len,
                         input int exp_writes, input logic exp_err);
    clear_req();
    build_model(a, len);
    start_req(tag, a, len);
    wait_done(tag, 6000);
    verify(tag, exp_writes, exp_err);
  endtask

  // AXI slave and traffic monitor: samples on the falling edge, drives just after the rising edge.
  initial begin : axi_slave
    logic ar_hs, r_hs, r_last, pv_valid, pv_ready;
    logic [ADDR_W-1:0] pv_addr;
    logic [7:0]        pv_len;
    logic [DATA_W-1:0] beat_data;
    int bp_cnt;
    pv_valid = 1'b0; pv_ready = 1'b0; pv_addr = '0; pv_len = '0; bp_cnt = 0;
    axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RDATA = '0;
    axi.M_AXI_RLAST = 1'b0; axi.M_AXI_RRESP = 2'b00; axi.M_AXI_RID = ARID_VAL;
    rd_fifo_afull = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      ar_hs  = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
      r_hs   = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
      r_last = axi.M_AXI_RLAST;
      if (aresetn) begin
        if (ar_hs) begin
          ar_addr_q.push_back(axi.M_AXI_ARADDR);
          ar_len_q.push_back(axi.M_AXI_ARLEN);
        end
        if (pv_valid && !pv_ready && (!axi.M_AXI_ARVALID || axi.M_AXI_ARADDR !== pv_addr ||
                                      axi.M_AXI_ARLEN !== pv_len))
          ar_unstable++;
        if (r_hs) sent_q.push_back(axi.M_AXI_RDATA);
        if (rd_fifo_we) begin
          wr_q.push_back(rd_fifo_data);
          last_wr_cyc = cyc;
        end
        if (axi.M_AXI_RVALID && !axi.M_AXI_RREADY) begin
          stall_cycles++;
          if (rd_fifo_we) stall_wr++;
        end
        if (axi.M_AXI_RVALID && (axi.M_AXI_RREADY !== !rd_fifo_afull)) rready_bad++;
        if (rd_done) begin
          done_cycles++;
          done_err = rd_err;
          done_cyc = cyc;
        end
      end
      pv_valid = axi.M_AXI_ARVALID;
      pv_ready = axi.M_AXI_ARREADY;
      pv_addr  = axi.M_AXI_ARADDR;
      pv_len   = axi.M_AXI_ARLEN;
      @(posedge aclk); #1;
      if (!aresetn) begin
        pend_q.delete();
        cur_beat = 0;
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RLAST   = 1'b0;
      end else begin
        if (ar_hs) pend_q.push_back(int'(pv_len) + 1);
        if (r_hs) begin
          req_beat++;
          if (r_last) begin
            if (pend_q.size() > 0) void'(pend_q.pop_front());
            cur_beat = 0;
          end else begin
            cur_beat++;
          end
        end
        axi.M_AXI_ARREADY = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!(axi.M_AXI_RVALID && !r_hs)) begin
          if (pend_q.size() > 0 && (!rv_rand || $urandom_range(0, 2) != 0)) begin
            for (int k = 0; k < DATA_W / 32; k++) beat_data[k*32 +: 32] = $urandom;
            axi.M_AXI_RDATA  = beat_data;
            axi.M_AXI_RVALID = 1'b1;
            axi.M_AXI_RID    = ARID_VAL;
            axi.M_AXI_RRESP  = (req_beat == err_beat - 1) ? 2'b10 : 2'b00;
            axi.M_AXI_RLAST  = (early_last > 0) ? (cur_beat == early_last - 1)
                                                : (cur_beat == pend_q[0] - 1);
          end else begin
            axi.M_AXI_RVALID = 1'b0;
            axi.M_AXI_RLAST  = 1'b0;
          end
        end
        if (bp_mode) begin
          bp_cnt++;
          rd_fifo_afull = ((bp_cnt / 3) % 2) == 1;
        end else if (af_rand) begin
          rd_fifo_afull = ($urandom_range(0, 3) == 0);
        end else begin
          rd_fifo_afull = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    aresetn = 1'b0; rd_start = 1'b0; rd_adrs = '0; rd_len = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst:arvalid", axi.M_AXI_ARVALID, 1'b0);
    check("rst:rready", axi.M_AXI_RREADY, 1'b0);
    check("rst:fifo_we", rd_fifo_we, 1'b0);
    check("rst:rd_done", rd_done, 1'b0);
    check("rst:rd_err", rd_err, 1'b0);
    check("rst:rd_ready", rd_ready, 1'b1);
    check("rst:araddr", axi.M_AXI_ARADDR, '0);
    check("rst:arlen", axi.M_AXI_ARLEN, '0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // Single short burst with first-AR latency and constant AR fields
    clear_req();
    build_model(32'h1000, 4);
    start_req("basic", 32'h1000, 4);
    check("basic:arvalid_calc", axi.M_AXI_ARVALID, 1'b0);
    check("basic:rd_ready_busy", rd_ready, 1'b0);
    @(posedge aclk); #1;
    check("basic:arvalid_up", axi.M_AXI_ARVALID, 1'b1);
    check("basic:araddr", axi.M_AXI_ARADDR, 32'h1000);
    check("basic:arlen", axi.M_AXI_ARLEN, 8'd3);
    check("basic:arsize", axi.M_AXI_ARSIZE, 3'd5);
    check("basic:arburst", axi.M_AXI_ARBURST, 2'b01);
    check("basic:arid", axi.M_AXI_ARID, ARID_VAL);
    wait_done("basic", 200);
    verify("basic", 4, 1'b0);

    // Multi-burst split at the burst cap; a stray RD_START mid-request must be ignored
    clear_req();
    build_model(32'h0, 300);
    start_req("long", 32'h0, 300);
    repeat (20) @(posedge aclk);
    #1;
    rd_len = 16'd5; rd_start = 1'b1;
    @(posedge aclk); #1;
    rd_start = 1'b0;
    wait_done("long", 6000);
    verify("long", 300, 1'b0);
    check("long:burst_count_fixed", ar_len_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("long:arlen_fixed[%0d]", i), ar_len_q[i], t2_len[i]);
      check($sformatf("long:araddr_fixed[%0d]", i), ar_addr_q[i], t2_addr[i]);
    end

    // 4 KB page split
    run_req("split4k", 32'h0FC0, 8, 8, 1'b0);
    check("split4k:arlen0", ar_len_q[0], 8'd1);
    check("split4k:araddr1", ar_addr_q[1], 32'h1000);
    check("split4k:arlen1", ar_len_q[1], 8'd5);

    // FIFO back-pressure toggling every 3 cycles
    bp_mode = 1;
    run_req("bp", 32'h3000, 64, 64, 1'b0);
    check("bp:stalls_seen", (stall_cycles > 0), 1'b1);
    bp_mode = 0;

    // Error responses
    err_beat = 2;
    run_req("rresp_err", 32'h4000, 4, 4, 1'b1);
    err_beat = 0;
    early_last = 3;
    run_req("early_last", 32'h5000, 4, 3, 1'b1);
    early_last = 0;

    // Zero-length request
    clear_req();
    start_req("len0", 32'h40, 0);
    @(negedge aclk);
    check("len0:rd_done", rd_done, 1'b1);
    check("len0:rd_err", rd_err, 1'b0);
    check("len0:arvalid", axi.M_AXI_ARVALID, 1'b0);
    @(posedge aclk); #1;
    repeat (3) @(posedge aclk);
    #1;
    check("len0:done_width", done_cycles, 1);
    check("len0:no_ar", ar_addr_q.size(), 0);

    // Reset in the middle of the data phase
    clear_req();
    start_req("rst_mid", 32'h2000, 64);
    n = 0;
    while (wr_q.size() < 5 && n < 2000) begin
      @(posedge aclk); #1;
      n++;
    end
    check("rst_mid:reached_data", (wr_q.size() >= 5), 1'b1);
    #1;
    aresetn = 1'b0;
    #1;
    check("rst_mid:arvalid", axi.M_AXI_ARVALID, 1'b0);
    check("rst_mid:rready", axi.M_AXI_RREADY, 1'b0);
    check("rst_mid:fifo_we", rd_fifo_we, 1'b0);
    check("rst_mid:rd_done", rd_done, 1'b0);
    check("rst_mid:rd_err", rd_err, 1'b0);
    check("rst_mid:rd_ready", rd_ready, 1'b1);
    check("rst_mid:araddr", axi.M_AXI_ARADDR, '0);
    check("rst_mid:arlen", axi.M_AXI_ARLEN, '0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_mid:no_done_pulse", done_cycles, 0);
    run_req("post_rst", 32'h2000, 70, 70, 1'b0);

    // Address wrap at the top of the address space
    run_req("wrap", 32'hFFFF_FF00, 20, 20, 1'b0);

    // Randomised requests with random slave timing and FIFO pressure
    ar_rand = 1; rv_rand = 1; af_rand = 1;
    for (int i = 0; i < 6; i++) begin
      r_addr = $urandom;
      if (i % 2 == 0) r_addr = (r_addr & 32'hFFFF_F000) | ADDR_W'($urandom_range(3584, 4095));
      r_len = $urandom_range(1, 300);
      run_req($sformatf("rand%0d", i), r_addr, r_len, r_len, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
